// File: rtl/host_link_bridge.sv
// host_link_bridge
//   Host-side link bridge for main_core_serialCmd. Decodes a framed byte
//   stream from the link into core commands (cmd) and input words (in), and
//   serializes core result words (out) back onto the link, MSB first.
//
//   Frame header [7:6]: 00 CMD (CMD_BYTES little-endian payload bytes),
//   01 DATA (count byte, then count x 8 bytes MSB first), 10 READ (count
//   byte; count core words are emitted), 11 invalid. A count of 0 means 256.
//
//   Optional feature macro: HOST_LINK_BRIDGE_ACK_EN
//     Defined: 0xA5 after a completed CMD/DATA frame, 0xEE after an invalid
//     header; rx is held off until the ACK byte leaves.
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   rx_byte/rx_valid/rx_ready      link byte input
//   tx_byte/tx_valid/tx_ready      link byte output
//   cmd/cmd_hasAny/cmd_consume     command to core
//   in/in_isReady/in_canReceive    data word to core
//   out/out_isReady/out_canReceive result word from core
module host_link_bridge #(
  parameter int unsigned CMD_W     = 16,
  parameter int unsigned CMD_BYTES = (CMD_W + 7) / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_byte,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [CMD_W-1:0]  cmd,
  output logic              cmd_hasAny,
  input  logic              cmd_consume,
  output logic [63:0]       in,
  output logic              in_isReady,
  input  logic              in_canReceive,
  input  logic [63:0]       out,
  input  logic              out_isReady,
  output logic              out_canReceive
);

  localparam logic [2:0] CMD_LAST = 3'(CMD_BYTES - 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_CMD_COL   = 4'd1;
  localparam logic [3:0] S_CMD_ISS   = 4'd2;
  localparam logic [3:0] S_DATA_CNT  = 4'd3;
  localparam logic [3:0] S_DATA_COL  = 4'd4;
  localparam logic [3:0] S_DATA_ISS  = 4'd5;
  localparam logic [3:0] S_READ_CNT  = 4'd6;
  localparam logic [3:0] S_READ_WAIT = 4'd7;
  localparam logic [3:0] S_READ_EMIT = 4'd8;
`ifdef HOST_LINK_BRIDGE_ACK_EN
  localparam logic [3:0] S_ACK       = 4'd9;
`endif

  logic [3:0]       state_q,    state_d;
  logic [2:0]       byte_idx_q, byte_idx_d;
  logic [8:0]       word_cnt_q, word_cnt_d;
  logic [CMD_W-1:0] cmd_q,      cmd_d;
  logic [63:0]      in_q,       in_d;
  logic [63:0]      rd_word_q,  rd_word_d;
`ifdef HOST_LINK_BRIDGE_ACK_EN
  logic [7:0]       ack_q,      ack_d;
`endif

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_cnt_d = word_cnt_q;
    cmd_d      = cmd_q;
    in_d       = in_q;
    rd_word_d  = rd_word_q;
`ifdef HOST_LINK_BRIDGE_ACK_EN
    ack_d      = ack_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          byte_idx_d = '0;
          word_cnt_d = '0;
          case (rx_byte[7:6])
            2'b00: begin
              state_d = S_CMD_COL;
              cmd_d   = '0;
            end
            2'b01:   state_d = S_DATA_CNT;
            2'b10:   state_d = S_READ_CNT;
            default: begin
`ifdef HOST_LINK_BRIDGE_ACK_EN
              ack_d   = 8'hEE;
              state_d = S_ACK;
`else
              state_d = S_IDLE;
`endif
            end
          endcase
        end
      end
      S_CMD_COL: begin
        if (rx_valid) begin
          // Little-endian payload; bits of the last byte above CMD_W fall off.
          for (int unsigned j = 0; j < CMD_W; j++) begin
            if (byte_idx_q == 3'(j / 8)) cmd_d[j] = rx_byte[3'(j % 8)];
          end
          if (byte_idx_q == CMD_LAST) begin
            byte_idx_d = '0;
            state_d    = S_CMD_ISS;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
          end
        end
      end
      S_CMD_ISS: begin
        if (cmd_consume) begin
          cmd_d = '0;
`ifdef HOST_LINK_BRIDGE_ACK_EN
          ack_d   = 8'hA5;
          state_d = S_ACK;
`else
          state_d = S_IDLE;
`endif
        end
      end
      S_DATA_CNT: begin
        if (rx_valid) begin
          // Count 0 encodes 256 in the 9-bit counter.
          word_cnt_d = {rx_byte == 8'd0, rx_byte};
          byte_idx_d = '0;
          state_d    = S_DATA_COL;
        end
      end
      S_DATA_COL: begin
        if (rx_valid) begin
          in_d = {in_q[55:0], rx_byte};
          if (byte_idx_q == 3'd7) begin
            byte_idx_d = '0;
            state_d    = S_DATA_ISS;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
          end
        end
      end
      S_DATA_ISS: begin
        if (in_canReceive) begin
          in_d       = '0;
          word_cnt_d = word_cnt_q - 9'd1;
          if (word_cnt_q == 9'd1) begin
`ifdef HOST_LINK_BRIDGE_ACK_EN
            ack_d   = 8'hA5;
            state_d = S_ACK;
`else
            state_d = S_IDLE;
`endif
          end else begin
            state_d = S_DATA_COL;
          end
        end
      end
      S_READ_CNT: begin
        if (rx_valid) begin
          word_cnt_d = {rx_byte == 8'd0, rx_byte};
          byte_idx_d = '0;
          state_d    = S_READ_WAIT;
        end
      end
      S_READ_WAIT: begin
        if (out_isReady) begin
          rd_word_d  = out;
          byte_idx_d = '0;
          state_d    = S_READ_EMIT;
        end
      end
      S_READ_EMIT: begin
        // tx_byte is the top byte of the latched word; shift on each transfer.
        if (tx_ready) begin
          rd_word_d = {rd_word_q[55:0], 8'h00};
          if (byte_idx_q == 3'd7) begin
            byte_idx_d = '0;
            word_cnt_d = word_cnt_q - 9'd1;
            state_d    = (word_cnt_q == 9'd1) ? S_IDLE : S_READ_WAIT;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
          end
        end
      end
`ifdef HOST_LINK_BRIDGE_ACK_EN
      S_ACK: begin
        if (tx_ready) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      byte_idx_q <= '0;
      word_cnt_q <= '0;
      cmd_q      <= '0;
      in_q       <= '0;
      rd_word_q  <= '0;
`ifdef HOST_LINK_BRIDGE_ACK_EN
      ack_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      word_cnt_q <= word_cnt_d;
      cmd_q      <= cmd_d;
      in_q       <= in_d;
      rd_word_q  <= rd_word_d;
`ifdef HOST_LINK_BRIDGE_ACK_EN
      ack_q      <= ack_d;
`endif
    end
  end

  // rst gates rx_ready directly so the link sees 0 for the whole reset pulse.
  assign rx_ready = ~rst & ((state_q == S_IDLE)     || (state_q == S_CMD_COL) ||
                            (state_q == S_DATA_CNT) || (state_q == S_DATA_COL) ||
                            (state_q == S_READ_CNT));

  assign cmd            = cmd_q;
  assign cmd_hasAny     = (state_q == S_CMD_ISS);
  assign in             = in_q;
  assign in_isReady     = (state_q == S_DATA_ISS);
  assign out_canReceive = (state_q == S_READ_WAIT);

`ifdef HOST_LINK_BRIDGE_ACK_EN
  assign tx_valid = (state_q == S_READ_EMIT) || (state_q == S_ACK);
  assign tx_byte  = (state_q == S_ACK) ? ack_q : rd_word_q[63:56];
`else
  assign tx_valid = (state_q == S_READ_EMIT);
  assign tx_byte  = rd_word_q[63:56];
`endif

endmodule

// File: tb/tb_host_link_bridge.sv
module tb_host_link_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [15:0] cmd;
  logic        cmd_hasAny;
  logic        cmd_consume = 1'b0;
  logic [63:0] in;
  logic        in_isReady;
  logic        in_canReceive = 1'b0;
  logic [63:0] out = '0;
  logic        out_isReady = 1'b0;
  logic        out_canReceive;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;

  host_link_bridge #(.CMD_W(16)) dut (
    .clk(clk), .rst(rst),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cmd(cmd), .cmd_hasAny(cmd_hasAny), .cmd_consume(cmd_consume),
    .in(in), .in_isReady(in_isReady), .in_canReceive(in_canReceive),
    .out(out), .out_isReady(out_isReady), .out_canReceive(out_canReceive)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (in_isReady && in_canReceive) hs_count++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Presents one byte and returns 1 ns after the edge that consumed it.
  task automatic send_byte(input logic [7:0] b);
    int unsigned n = 0;
    rx_byte  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: rx_ready=%b required 1 (byte %h)", rx_ready, b);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] w);
    for (int k = 0; k < 8; k++) send_byte(w[63-8*k -: 8]);
  endtask

`ifdef HOST_LINK_BRIDGE_ACK_EN
  task automatic expect_ack(input logic [7:0] b);
    checks++;
    if (tx_valid !== 1'b1 || tx_byte !== b) begin
      errors++;
      $display("FAIL ack_byte: tx_valid=%b tx_byte=%h required 1/%h", tx_valid, tx_byte, b);
    end
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
  endtask
`endif

  task automatic test_reset;
    #1 rst = 1'b1;
    #2;
    checks++;
    if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready: got %b required 0", rx_ready); end
    checks++;
    if ({tx_valid, cmd_hasAny, in_isReady, out_canReceive} !== 4'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b required 0000", {tx_valid, cmd_hasAny, in_isReady, out_canReceive});
    end
    checks++;
    if (cmd !== 16'h0 || in !== 64'h0 || tx_byte !== 8'h0) begin
      errors++;
      $display("FAIL reset_data: cmd=%h in=%h tx_byte=%h required zeros", cmd, in, tx_byte);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rx_ready !== 1'b1) begin errors++; $display("FAIL post_reset_rx_ready: got %b required 1", rx_ready); end
  endtask

  task automatic test_idle_strobes;
    cmd_consume   = 1'b1;
    in_canReceive = 1'b1;
    @(posedge clk); #1;
    cmd_consume   = 1'b0;
    in_canReceive = 1'b0;
    checks++;
    if ({cmd_hasAny, in_isReady, rx_ready} !== 3'b001) begin
      errors++;
      $display("FAIL idle_strobes: hasAny/isReady/rx_ready=%b required 001", {cmd_hasAny, in_isReady, rx_ready});
    end
  endtask

  task automatic test_cmd;
    send_byte(8'h00);
    send_byte(8'h34);
    send_byte(8'h12);
    checks++;
    if (cmd_hasAny !== 1'b1 || cmd !== 16'h1234) begin
      errors++;
      $display("FAIL cmd_issue: hasAny=%b cmd=%h required 1/1234", cmd_hasAny, cmd);
    end
    checks++;
    if (rx_ready !== 1'b0) begin errors++; $display("FAIL cmd_rx_hold: rx_ready=%b required 0", rx_ready); end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      checks++;
      if (cmd_hasAny !== 1'b1 || cmd !== 16'h1234) begin
        errors++;
        $display("FAIL cmd_hold_%0d: hasAny=%b cmd=%h required 1/1234", c, cmd_hasAny, cmd);
      end
    end
    cmd_consume = 1'b1;
    @(posedge clk); #1;
    cmd_consume = 1'b0;
    checks++;
    if (cmd_hasAny !== 1'b0 || cmd !== 16'h0) begin
      errors++;
      $display("FAIL cmd_consumed: hasAny=%b cmd=%h required 0/0000", cmd_hasAny, cmd);
    end
`ifdef HOST_LINK_BRIDGE_ACK_EN
    expect_ack(8'hA5);
`endif
    checks++;
    if (rx_ready !== 1'b1) begin errors++; $display("FAIL cmd_idle: rx_ready=%b required 1", rx_ready); end
  endtask

  task automatic test_data;
    send_byte(8'h40);
    send_byte(8'h02);
    send_word(64'h0102030405060708);
    checks++;
    if (in_isReady !== 1'b1 || in !== 64'h0102030405060708) begin
      errors++;
      $display("FAIL data_w0: isReady=%b in=%h required 1/0102030405060708", in_isReady, in);
    end
    // Offer the next word's first byte during the stall; it must not be taken.
    rx_byte  = 8'h11;
    rx_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (in_isReady !== 1'b1 || in !== 64'h0102030405060708 || rx_ready !== 1'b0) begin
        errors++;
        $display("FAIL data_stall_%0d: isReady=%b in=%h rx_ready=%b required 1/0102030405060708/0",
                 c, in_isReady, in, rx_ready);
      end
      @(posedge clk); #1;
    end
    in_canReceive = 1'b1;
    @(posedge clk); #1;
    in_canReceive = 1'b0;
    checks++;
    if (in_isReady !== 1'b0 || in !== 64'h0) begin
      errors++;
      $display("FAIL data_w0_taken: isReady=%b in=%h required 0/0", in_isReady, in);
    end
    send_word(64'h1112131415161718);
    checks++;
    if (in_isReady !== 1'b1 || in !== 64'h1112131415161718) begin
      errors++;
      $display("FAIL data_w1: isReady=%b in=%h required 1/1112131415161718", in_isReady, in);
    end
    in_canReceive = 1'b1;
    @(posedge clk); #1;
    in_canReceive = 1'b0;
`ifdef HOST_LINK_BRIDGE_ACK_EN
    expect_ack(8'hA5);
`endif
    checks++;
    if (in_isReady !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL data_done: isReady=%b rx_ready=%b required 0/1", in_isReady, rx_ready);
    end
  endtask

  task automatic test_read;
    logic [63:0] exp_w = 64'h0011223344556677;
    logic [7:0]  rec [8];
    int          got = 0;
    int unsigned cyc = 0;
    send_byte(8'h80);
    send_byte(8'h01);
    checks++;
    if (out_canReceive !== 1'b1) begin errors++; $display("FAIL read_wait: out_canReceive=%b required 1", out_canReceive); end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL read_idle_tx: tx_valid=%b required 0", tx_valid); end
    out         = exp_w;
    out_isReady = 1'b1;
    @(posedge clk); #1;
    out_isReady = 1'b0;
    out         = '0;
    checks++;
    if (out_canReceive !== 1'b0 || tx_valid !== 1'b1 || tx_byte !== 8'h00) begin
      errors++;
      $display("FAIL read_first: canRecv=%b tx_valid=%b tx_byte=%h required 0/1/00", out_canReceive, tx_valid, tx_byte);
    end
    while (got < 8 && cyc < 64) begin
      tx_ready = cyc[0];
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        rec[got] = tx_byte;
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    tx_ready = 1'b0;
    checks++;
    if (got != 8) begin errors++; $display("FAIL read_count: got %0d bytes required 8", got); end
    for (int k = 0; k < got; k++) begin
      checks++;
      if (rec[k] !== exp_w[63-8*k -: 8]) begin
        errors++;
        $display("FAIL read_byte_%0d: got %h required %h", k, rec[k], exp_w[63-8*k -: 8]);
      end
    end
    checks++;
    if (tx_valid !== 1'b0 || rx_ready !== 1'b1 || out_canReceive !== 1'b0) begin
      errors++;
      $display("FAIL read_done: tx_valid=%b rx_ready=%b canRecv=%b required 0/1/0", tx_valid, rx_ready, out_canReceive);
    end
  endtask

  task automatic test_count0;
    int          base = hs_count;
    logic [63:0] w;
    send_byte(8'h40);
    send_byte(8'h00);
    in_canReceive = 1'b1;
    for (int n = 0; n < 256; n++) begin
      w = '0;
      for (int k = 0; k < 8; k++) w = {w[55:0], 8'(n + k * 37)};
      send_word(w);
      checks++;
      if (in_isReady !== 1'b1 || in !== w) begin
        errors++;
        $display("FAIL count0_word_%0d: isReady=%b in=%h required 1/%h", n, in_isReady, in, w);
      end
    end
    @(posedge clk); #1;
    in_canReceive = 1'b0;
    checks++;
    if (hs_count - base != 256) begin
      errors++;
      $display("FAIL count0_handshakes: got %0d required 256", hs_count - base);
    end
`ifdef HOST_LINK_BRIDGE_ACK_EN
    expect_ack(8'hA5);
`endif
    checks++;
    if (in_isReady !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL count0_idle: isReady=%b rx_ready=%b required 0/1", in_isReady, rx_ready);
    end
  endtask

  task automatic test_invalid;
    send_byte(8'hC0);
`ifdef HOST_LINK_BRIDGE_ACK_EN
    checks++;
    if (rx_ready !== 1'b0) begin errors++; $display("FAIL invalid_rx_hold: rx_ready=%b required 0", rx_ready); end
    expect_ack(8'hEE);
`endif
    checks++;
    if (rx_ready !== 1'b1 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL invalid_idle: rx_ready=%b tx_valid=%b required 1/0", rx_ready, tx_valid);
    end
    send_byte(8'h00);
    send_byte(8'hCD);
    send_byte(8'hAB);
    checks++;
    if (cmd_hasAny !== 1'b1 || cmd !== 16'hABCD) begin
      errors++;
      $display("FAIL invalid_next_cmd: hasAny=%b cmd=%h required 1/abcd", cmd_hasAny, cmd);
    end
    cmd_consume = 1'b1;
    @(posedge clk); #1;
    cmd_consume = 1'b0;
`ifdef HOST_LINK_BRIDGE_ACK_EN
    expect_ack(8'hA5);
`endif
  endtask

  task automatic test_reset_mid;
    send_byte(8'h00);
    send_byte(8'hEF);
    send_byte(8'hBE);
    checks++;
    if (cmd_hasAny !== 1'b1 || cmd !== 16'hBEEF) begin
      errors++;
      $display("FAIL rst_cmd_pre: hasAny=%b cmd=%h required 1/beef", cmd_hasAny, cmd);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (cmd_hasAny !== 1'b0 || cmd !== 16'h0) begin
      errors++;
      $display("FAIL rst_cmd_async: hasAny=%b cmd=%h required 0/0", cmd_hasAny, cmd);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    send_byte(8'h40);
    send_byte(8'h01);
    for (int k = 0; k < 5; k++) send_byte(8'h60 + 8'(k));
    checks++;
    if (rx_ready !== 1'b1) begin errors++; $display("FAIL rst_data_pre: rx_ready=%b required 1", rx_ready); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (in_isReady !== 1'b0 || rx_ready !== 1'b0 || in !== 64'h0) begin
      errors++;
      $display("FAIL rst_data_async: isReady=%b rx_ready=%b in=%h required 0/0/0", in_isReady, rx_ready, in);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    send_byte(8'h40);
    send_byte(8'h01);
    send_word(64'hA0A1A2A3A4A5A6A7);
    checks++;
    if (in_isReady !== 1'b1 || in !== 64'hA0A1A2A3A4A5A6A7) begin
      errors++;
      $display("FAIL rst_data_fresh: isReady=%b in=%h required 1/a0a1a2a3a4a5a6a7", in_isReady, in);
    end
    in_canReceive = 1'b1;
    @(posedge clk); #1;
    in_canReceive = 1'b0;
`ifdef HOST_LINK_BRIDGE_ACK_EN
    expect_ack(8'hA5);
`endif
    checks++;
    if (in_isReady !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_data_done: isReady=%b rx_ready=%b required 0/1", in_isReady, rx_ready);
    end
  endtask

  initial begin
    test_reset();
    test_idle_strobes();
    test_cmd();
    test_data();
    test_read();
    test_count0();
    test_invalid();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/host_link_bridge.md
# host_link_bridge

Host-side link bridge for `main_core_serialCmd`. It takes a framed byte stream from an external link (UART/FIFO side) and drives the core's three ports:
- `cmd`/`cmd_hasAny`/`cmd_consume` as command initiator;
- `in`/`in_isReady`/`in_canReceive` as input-word producer;
- `out`/`out_isReady`/`out_canReceive` as output-word consumer.

Core output words are serialized back onto a byte stream. It is the other end of the word/command handshake that the core bench emulates.

## Interface
Parameters:
- `CMD_W`, 16: width of core `cmd` (set to `MainCoreCMD_which_SIZE+MainCoreSerialCMD_SIZE` at instantiation); 1..32.
- `CMD_BYTES`, derived `(CMD_W+7)/8`: bytes per command payload.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `rx_byte` in 8: link byte in.
- `rx_valid` in 1: `rx_byte` valid.
- `rx_ready` out 1: bridge accepts byte; transfer on `rx_valid&rx_ready` at posedge.
- `tx_byte` out 8: link byte out.
- `tx_valid` out 1: `tx_byte` valid.
- `tx_ready` in 1: link accepts; transfer on `tx_valid&tx_ready`.
- `cmd` out CMD_W: command to core.
- `cmd_hasAny` out 1: command pending.
- `cmd_consume` in 1: core takes command at this posedge.
- `in` out 64: data word to core.
- `in_isReady` out 1: word pending.
- `in_canReceive` in 1: core takes word when `in_isReady&in_canReceive` at posedge.
- `out` in 64: core result word.
- `out_isReady` in 1: result valid.
- `out_canReceive` out 1: bridge takes word when `out_isReady&out_canReceive` at posedge.

## Operation
Frame header byte `[7:6]` type; `[5:0]` ignored:
- `00` CMD: followed by `CMD_BYTES` bytes, little-endian. Bits above CMD_W are dropped.
- `01` DATA: followed by count byte N (0 means 256), then N words of 8 bytes each, MSB first.
- `10` READ: followed by count byte N (0 means 256). Bridge pulls N core words and emits each as 8 bytes, MSB first.
- `11` invalid: header consumed, return to IDLE.

FSM states:
- IDLE: header → CMD_COL / DATA_CNT / READ_CNT / IDLE.
- CMD_COL: after `CMD_BYTES` bytes → CMD_ISS.
- CMD_ISS: `cmd_hasAny=1` with `cmd` stable; on `cmd_consume` → ACK or IDLE.
- DATA_CNT: count byte → DATA_COL.
- DATA_COL: after 8 bytes → DATA_ISS.
- DATA_ISS: `in_isReady=1`; on acceptance, remaining words → DATA_COL, otherwise → ACK or IDLE.
- READ_CNT: count byte → READ_WAIT.
- READ_WAIT: `out_canReceive=1`; on acceptance, latch the word → READ_EMIT.
- READ_EMIT: 8 tx bytes; after the last, remaining words → READ_WAIT, otherwise → IDLE.
- ACK (macro only): emit one byte, then → IDLE.

Signal rules:
- `rx_ready=1` only in IDLE, CMD_COL, DATA_CNT, DATA_COL, READ_CNT.
- `cmd`/`in` are zeroed when their handshake completes.
- Word counter is 9-bit, so count 0 maps to 256 with no wrap.
- Counter and byte index are reset on each header.

## Timing
Reset:
- All outputs 0 (`rx_ready` 0 while `rst`); FSM in IDLE.
- Reset mid-frame discards partial data and any pending `cmd_hasAny`/`in_isReady` immediately (asynchronous).

Byte rate: 1 rx byte per cycle sustained within collect states.

Latencies:
- `cmd_hasAny` rises the cycle after the last command byte is accepted; it falls the cycle after the consume edge.
- `in_isReady` rises the cycle after the 8th byte; it falls the cycle after acceptance.
- First `tx_valid` comes 1 cycle after the `out` acceptance edge.
- `tx_byte` is held while `tx_valid&~tx_ready`.
- `out_canReceive` is 0 during READ_EMIT, so no overlap or buffering.

Edge cases:
- `cmd_consume` or `in_canReceive` asserted while the bridge has nothing pending: ignored.
- `rx_valid` while `rx_ready=0`: byte not consumed, stays on the link.

## Configuration
`HOST_LINK_BRIDGE_ACK_EN`:
- Defined: after a completed CMD frame (consume edge) or DATA frame (last word accepted), emit `0xA5`. After an invalid header, emit `0xEE`. `rx_ready` is 0 until the ACK byte transfers. READ frames emit no ACK.
- Undefined: no ACK state; the bridge returns straight to IDLE and tx carries only READ data.

## Test plan
- CMD: rx `00,34,12` with `CMD_W=16`; core `cmd_consume` 3 cycles later → `cmd=16'h1234`, `cmd_hasAny` held 3+1 cycles, then 0. With ACK_EN, tx `A5`.
- DATA N=2: rx `40,02`, then bytes `0102030405060708`, `1112131415161718`; `in_canReceive` stalls 5 cycles on the first word → `in=0102030405060708` held until accepted, then `1112131415161718`; `rx_ready=0` during each stall.
- READ N=1: rx `80,01`; core `out=00112233_44556677` valid after 4 cycles; `tx_ready` toggles every other cycle → tx `00,11,22,33,44,55,66,77` in order with no duplicates; `out_canReceive` drops after acceptance.
- Count 0: rx `40,00` then 256 words → exactly 256 `in` handshakes, FSM back in IDLE.
- Invalid header: rx `C0`, then a CMD frame → header ignored (tx `EE` if ACK_EN); the next CMD completes normally.
- Reset mid-DATA: assert `rst` after 5 of 8 bytes → `in_isReady=0`, `rx_ready=0` asynchronously. After release, a fresh DATA frame issues the correct word.
